// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state constants and op-class helpers.
package mdu_pkg;

  localparam int unsigned OpW = 4;

  typedef enum logic [OpW-1:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMadd  = 4'd5,
    OpMaddu = 4'd6,
    OpMthi  = 4'd7,
    OpMtlo  = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } op_e;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_md_op(logic [OpW-1:0] op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu, OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_div_op(logic [OpW-1:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the E stage and the multiply/divide unit.
interface mdu_iter_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             req;
  logic             start;
  logic [OpW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output req, start, op, a, b,
    input  hi, lo, busy, done
  );

  modport slave (
    input  req, start, op, a, b,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/mdu_calc.sv
// Combinational HI/LO arithmetic: multiply, multiply-accumulate and divide,
// including the divide-by-zero and signed-overflow results.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [OpW-1:0]   op,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned W2 = 2 * WIDTH;

  logic [W2-1:0]    acc;
  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic             b_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] b_safe_s;
  logic [WIDTH-1:0] b_safe_u;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] q_u;
  logic [WIDTH-1:0] r_u;

  assign acc = {hi_in, lo_in};

  // Low 2W bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero  = (b == '0);
  assign div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  // Divisors are forced to 1 in the special cases so the dividers never see 0 or overflow.
  assign b_safe_s = (b_zero || div_ovf) ? WIDTH'(1) : b;
  assign b_safe_u = b_zero ? WIDTH'(1) : b;

  assign q_s = $signed(a) / $signed(b_safe_s);
  assign r_s = $signed(a) % $signed(b_safe_s);
  assign q_u = a / b_safe_u;
  assign r_u = a % b_safe_u;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    case (op)
      OpMult:  {hi_out, lo_out} = prod_s;
      OpMultu: {hi_out, lo_out} = prod_u;
      OpMadd:  {hi_out, lo_out} = acc + prod_s;
      OpMaddu: {hi_out, lo_out} = acc + prod_u;
      OpMsub:  {hi_out, lo_out} = acc - prod_s;
      OpMsubu: {hi_out, lo_out} = acc - prod_u;
      OpDiv: begin
        if (b_zero) begin
          hi_out = a;
          lo_out = '1;
        end else if (div_ovf) begin
          hi_out = '0;
          lo_out = a;
        end else begin
          hi_out = r_s;
          lo_out = q_s;
        end
      end
      OpDivu: begin
        if (b_zero) begin
          hi_out = a;
          lo_out = '1;
        end else begin
          hi_out = r_u;
          lo_out = q_u;
        end
      end
      default: begin
        hi_out = hi_in;
        lo_out = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with fixed per-class latency: the result is computed at issue,
// held for the latency window, then committed to HI/LO with a one-cycle done pulse.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  mdu_iter_if.slave   bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] tmp_hi_q, tmp_hi_d;
  logic [WIDTH-1:0] tmp_lo_q, tmp_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             accept;
  logic             mt_ok;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;

  // req flushes the E-stage instruction, so nothing new is issued or written under it.
  assign accept = bus.start && !bus.req && (state_q == IDLE) && is_md_op(bus.op);
  assign mt_ok  = !bus.start && !bus.req && (state_q == IDLE);

  mdu_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .a      (bus.a),
    .b      (bus.b),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .op     (bus.op),
    .hi_out (calc_hi),
    .lo_out (calc_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = BUSY;
          cnt_d    = is_div_op(bus.op) ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
          tmp_hi_d = calc_hi;
          tmp_lo_d = calc_lo;
        end else if (mt_ok && (bus.op == OpMthi)) begin
          hi_d = bus.a;
        end else if (mt_ok && (bus.op == OpMtlo)) begin
          lo_d = bus.a;
        end
      end
      BUSY: begin
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q == BUSY);
  assign bus.done = done_q;

endmodule
